// File: rtl/accum_rmw_ctrl.sv
// accum_rmw_ctrl
//   Read-modify-write controller for one accumulator bank on a pseudo dual-port
//   RAM. The write port is dedicated and the read port is registered with a
//   2-cycle latency. The block accepts one (addr, value) request per cycle.
//   In accumulate mode it writes mem + value back to the RAM. In overwrite mode
//   it writes value. A two-deep write history forwards recent writes, which
//   hides the stale-read window so that address reuse never needs a stall.
//   A clear sweep zeroes every word after the pipeline has drained.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready request handshake
//   in_addr/in_data   target word and operand
//   in_mode           0 = accumulate, 1 = overwrite
//   clear_start       pulse that requests a zero sweep of the whole bank
//   busy              pipeline holds an entry, or a drain/clear is in progress
//   clear_done        one-cycle pulse in the first IDLE cycle after a sweep
//   ram_rd_*          RAM read port (strobe and address are combinational)
//   ram_wr_*          RAM write port (combinational from S2 or the clear counter)
module accum_rmw_ctrl #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          in_mode,
    input  logic          clear_start,
    output logic          busy,
    output logic          clear_done,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_rd_data,
    output logic          ram_wr_en,
    output logic          ram_wr_we,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_wdata
);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          clear_done_nxt;

    logic          s1_valid, s2_valid;
    logic [AW-1:0] s1_addr, s2_addr;
    logic [DW-1:0] s1_data, s2_data;
    logic          s1_mode, s2_mode;

    logic          h1_valid, h2_valid;
    logic [AW-1:0] h1_addr, h2_addr;
    logic [DW-1:0] h1_data, h2_data;

    logic          accept;
    logic [DW-1:0] base;
    logic [DW-1:0] result;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        clear_done_nxt = 1'b0;
        in_ready       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (clear_start) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!s1_valid && !s2_valid) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1) begin
                    state_nxt      = IDLE;
                    clear_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept      = in_valid & in_ready;
    assign ram_rd_en   = accept;
    assign ram_rd_addr = in_addr;
    assign busy        = s1_valid | s2_valid | (state != IDLE);

    // H1 is the write that landed at the previous edge; the RAM read for S2 missed it.
    // H2 covers the read-first collision, where a read and a write hit the same edge.
    always_comb begin
        if (h1_valid && h1_addr == s2_addr)      base = h1_data;
        else if (h2_valid && h2_addr == s2_addr) base = h2_data;
        else                                     base = ram_rd_data;
    end

    assign result = s2_mode ? s2_data : base + s2_data;

    always_comb begin
        ram_wr_en    = 1'b0;
        ram_wr_addr  = '0;
        ram_wr_wdata = '0;
        if (state == CLEAR) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = cnt;
        end else if (s2_valid) begin
            ram_wr_en    = 1'b1;
            ram_wr_addr  = s2_addr;
            ram_wr_wdata = result;
        end
    end

    assign ram_wr_we = ram_wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            clear_done <= 1'b0;
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s1_data    <= '0;
            s1_mode    <= 1'b0;
            s2_valid   <= 1'b0;
            s2_addr    <= '0;
            s2_data    <= '0;
            s2_mode    <= 1'b0;
            h1_valid   <= 1'b0;
            h1_addr    <= '0;
            h1_data    <= '0;
            h2_valid   <= 1'b0;
            h2_addr    <= '0;
            h2_data    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            clear_done <= clear_done_nxt;
            s1_valid   <= accept;
            s1_addr    <= in_addr;
            s1_data    <= in_data;
            s1_mode    <= in_mode;
            s2_valid   <= s1_valid;
            s2_addr    <= s1_addr;
            s2_data    <= s1_data;
            s2_mode    <= s1_mode;
            h1_valid   <= ram_wr_en;
            h1_addr    <= ram_wr_addr;
            h1_data    <= ram_wr_wdata;
            h2_valid   <= h1_valid;
            h2_addr    <= h1_addr;
            h2_data    <= h1_data;
        end
    end

endmodule
